// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions, hex glyph table and the all-off pattern
// shared by the 7-segment scanner and its decoder.
// All patterns are active low: a 0 bit lights the segment.
package seg7_pkg;

  // Bit positions within the SEG bus: a..g on [7:1], decimal point on [0].
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Every segment dark, decimal point included.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex glyphs with the decimal point off; A..F are drawn as A b C d E F.
  localparam logic [0:15][7:0] HEX_SEG = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,   // 0 1 2 3
    8'h99, 8'h49, 8'h41, 8'h1F,   // 4 5 6 7
    8'h01, 8'h09, 8'h11, 8'hC1,   // 8 9 A b
    8'h63, 8'h85, 8'h61, 8'h71    // C d E F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: one nibble plus decimal point to an active-low
// segment pattern. Purely combinational; one copy per digit.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Look up the glyph, then pull the dp segment low when requested.
  always_comb begin
    seg = HEX_SEG[nibble];
    if (dp) seg[SEG_DP] = 1'b0;
  end

endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: multiplexed NUM_DIGITS-digit hex display driver with PWM
// brightness, leading-zero blanking and a frame-coherent input latch.
// Optional build macro SEG7_DEADTIME_EN: blank every digit for the first
// cycle of each slot so the segment bus can settle without ghosting.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 4096,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   DIGIT,
  output logic                    FRAME
);

  localparam int PW   = $clog2(DIV);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP = DIV >> BRIGHT_W;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic                    run;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic                    latch_en;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_blz;
  logic [4*NUM_DIGITS-1:0] cur_value;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic                    cur_blz;
  logic [NUM_DIGITS-1:0][7:0] dig_seg;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [31:0]             thresh;
  logic                    pwm_on;
  logic                    gap;
  logic                    lit;

  // run holds the scan at slot 0 for the cycle after reset release so the
  // first frame starts (and latches) cleanly with FRAME still low in reset.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      run <= 1'b0;
      pre <= '0;
      idx <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (pre == PRE_MAX) begin
          pre <= '0;
          idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  assign latch_en = run && (pre == '0) && (idx == '0);
  assign FRAME    = latch_en;

  // Shadow copy of the display inputs, refreshed only at frame start.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blz   <= 1'b0;
    end else if (latch_en) begin
      sh_value <= value;
      sh_dp    <= dp;
      sh_blz   <= blank_lz;
    end
  end

  // The first slot cycle renders from the inputs being latched right now,
  // so the whole new frame (including its first cycle) shows one snapshot.
  assign cur_value = latch_en ? value    : sh_value;
  assign cur_dp    = latch_en ? dp       : sh_dp;
  assign cur_blz   = latch_en ? blank_lz : sh_blz;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7_hex_decode u_dec (
      .nibble (cur_value[4*g +: 4]),
      .dp     (cur_dp[g]),
      .seg    (dig_seg[g])
    );
    if (g == 0) begin : g_lsd
      assign blank_vec[g] = 1'b0;
    end else begin : g_upper
      assign blank_vec[g] = cur_blz && ~|cur_value[4*NUM_DIGITS-1:4*g];
    end
  end

  assign thresh = 32'(brightness) * STEP;
  assign pwm_on = (&brightness) || (32'(pre) < thresh);

`ifdef SEG7_DEADTIME_EN
  assign gap = (pre == '0);
`else
  assign gap = 1'b0;
`endif

  assign lit = run && pwm_on && !gap && !blank_vec[idx];

  // Registered pin drive: at most one digit enable low, dark when unlit.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      SEG   <= SEG_OFF;
      DIGIT <= '1;
    end else if (lit) begin
      SEG   <= dig_seg[idx];
      DIGIT <= ~(NUM_DIGITS'(1) << idx);
    end else begin
      SEG   <= SEG_OFF;
      DIGIT <= '1;
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: scoreboard bench for seg7_scanner (4 digits, 16-cycle
// slots, 2-bit brightness). The driver predicts each cycle's pins from a
// time-based model and queues them; a negedge monitor pops and compares.
module tb_seg7_scanner;

  localparam int N   = 4;
  localparam int DIV = 16;
  localparam int BW  = 2;
  localparam int F   = N * DIV;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] digit;
    logic       frame;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b1;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [7:0]  SEG;
  logic [3:0]  DIGIT;
  logic        FRAME;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          j = 0;
  logic [15:0] sv;
  logic [3:0]  sd;
  logic        sb;

  // Lit segments of each hex glyph, by letter.
  string letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg7_scanner #(.NUM_DIGITS(N), .DIV(DIV), .BRIGHT_W(BW)) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .value      (value),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .SEG        (SEG),
    .DIGIT      (DIGIT),
    .FRAME      (FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t: got %0h, wanted %0h", name, $time, act, exp);
  endtask

  function automatic logic [7:0] hex_segs(input logic [3:0] n, input logic p);
    logic [7:0] r;
    string s;
    r = 8'hFF;
    s = letters[n];
    for (int i = 0; i < s.len(); i++) begin
      int k;
      k = int'(s[i]) - 97;
      r[7-k] = 1'b0;
    end
    if (p) r[0] = 1'b0;
    return r;
  endfunction

  // Pins expected while scan time s is being rendered, given the frame's
  // snapshot and the live brightness.
  function automatic exp_t model(input int s, input logic [15:0] v, input logic [3:0] d,
                                 input logic blz, input logic [1:0] b);
    exp_t e;
    int   phase;
    int   dig;
    bit   on;
    phase = s % DIV;
    dig   = (s / DIV) % N;
    on    = (b == 2'b11) || (phase < int'(b) * (DIV >> BW));
`ifdef SEG7_DEADTIME_EN
    if (phase == 0) on = 0;
`endif
    if (dig > 0 && blz && ((v >> (4 * dig)) == 16'h0)) on = 0;
    e.frame = 1'b0;
    if (on) begin
      e.seg   = hex_segs(v[4*dig +: 4], d[dig]);
      e.digit = 4'(~(1 << dig));
    end else begin
      e.seg   = 8'hFF;
      e.digit = 4'hF;
    end
    return e;
  endfunction

  // Inputs for scan time j are already on the pins; queue the pins for j+1.
  task automatic step();
    exp_t e;
    if (j % F == 0) begin
      sv = value;
      sd = dp;
      sb = blank_lz;
    end
    e = model(j, sv, sd, sb, brightness);
    e.frame = ((j + 1) % F == 0);
    q.push_back(e);
    @(posedge CLK);
    #1;
    j++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    repeat (2) begin
      @(negedge CLK);
      #1;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    #1;
    chk("rst_seg_now", SEG, 8'hFF);
    chk("rst_digit_now", DIGIT, 4'hF);
    repeat (5) begin
      @(negedge CLK);
      chk("rst_seg", SEG, 8'hFF);
      chk("rst_digit", DIGIT, 4'hF);
      chk("rst_frame", FRAME, 1'b0);
    end
    @(posedge CLK);
    #1;
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    j = 0;
    q.push_back('{seg: 8'hFF, digit: 4'hF, frame: 1'b1});
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("SEG", SEG, e.seg);
      chk("DIGIT", DIGIT, e.digit);
      chk("FRAME", FRAME, e.frame);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    run(2 * F);                         // plain scan of 1234
    brightness = 2'd1; run(F);          // quarter duty
    brightness = 2'd0; run(F);          // dark
    brightness = 2'd3; blank_lz = 1'b1;
    value = 16'h0050; run(F);           // digits 3,2 blanked
    value = 16'h0000; run(F);           // only digit 0
    value = 16'h0050; dp = 4'b1000; run(F);
    dp = 4'h0; blank_lz = 1'b0;
    value = 16'h1234; run(F + 20);      // stops inside the digit-1 slot
    value = 16'hABCD; run(F + 44);      // rest of frame stays 1234
    repeat (6 * F) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
      step();
    end
    drain();
    // Mid-frame reset while a digit is lit, then a fresh scan.
    brightness = 2'd3; blank_lz = 1'b0; value = 16'h8F21; dp = 4'h5;
    repeat (5) @(posedge CLK);
    #1;
    do_reset();
    run(F + 10);
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
